// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions: forward-select encodings, register constants and
// the in-flight destination record tracked by the ID-stage hazard unit.
package mips_pipe_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int DIV_LAT_DEF = 32;

  typedef struct packed {
    logic [4:0] wbadd;
    logic       regwrite;
    logic       memread;
  } shadow_t;

  // $0 is hardwired, so a write to it can never create a dependency.
  function automatic logic reg_match(input shadow_t s,
                                     input logic [4:0] rs, input logic [4:0] rt,
                                     input logic use_rs, input logic use_rt);
    return s.regwrite && (s.wbadd != REG_ZERO) &&
           ((use_rs && (s.wbadd == rs)) || (use_rt && (s.wbadd == rt)));
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// ID-stage instruction fields in, stall/flush/forward controls out.
interface hazard_stall_ctrl_if #(parameter int CNT_W = 16);

  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic [4:0]       id_wbadd;
  logic             id_regwrite;
  logic             id_memread;
  logic             id_is_branch;
  logic             id_is_div;
  logic             id_is_mdread;
  logic             branch_taken;

  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_bubble;
  logic [1:0]       brsrc1;
  logic [1:0]       brsrc2;
  logic             div_busy;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_wbadd, id_regwrite,
           id_memread, id_is_branch, id_is_div, id_is_mdread, branch_taken,
    input  pc_en, ifid_en, ifid_flush, idex_bubble, brsrc1, brsrc2,
           div_busy, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_wbadd, id_regwrite,
           id_memread, id_is_branch, id_is_div, id_is_mdread, branch_taken,
    output pc_en, ifid_en, ifid_flush, idex_bubble, brsrc1, brsrc2,
           div_busy, stall_cycles
  );

endinterface

// File: rtl/md_busy_counter.sv
// HI/LO busy tracker: loads the divide latency on issue and counts down to idle.
module md_busy_counter #(
  parameter int LAT = 32,
  parameter int W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic busy
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = W'(LAT);
    else if (cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard unit: stalls for load-use, ID-resolved branch operands and
// busy HI/LO, flushes IF/ID on taken branches, selects branch-compare forwards.
module hazard_stall_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = 16
) (
  input logic               clk,
  input logic               rst,
  hazard_stall_ctrl_if.slave hz
);

  shadow_t          id_fields;
  shadow_t          ex_q, ex_d;
  shadow_t          mem_q, mem_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic match_ex, match_mem;
  logic lu_hz, br_hz, md_hz, stall;
  logic div_issue, div_busy;

  always_comb begin
    id_fields.wbadd    = hz.id_wbadd;
    id_fields.regwrite = hz.id_regwrite;
    id_fields.memread  = hz.id_memread;

    match_ex  = reg_match(ex_q,  hz.id_rs, hz.id_rt, hz.id_use_rs, hz.id_use_rt);
    match_mem = reg_match(mem_q, hz.id_rs, hz.id_rt, hz.id_use_rs, hz.id_use_rt);

    // A load in MEM still has no value for the ID comparator; an ALU result there can be forwarded.
    lu_hz = ex_q.memread && match_ex;
    br_hz = hz.id_is_branch && (match_ex || (mem_q.memread && match_mem));
    md_hz = div_busy && (hz.id_is_mdread || hz.id_is_div);
    stall = lu_hz || br_hz || md_hz;

    div_issue = hz.id_is_div && !stall;

    ex_d  = stall ? '0 : id_fields;
    mem_d = ex_q;

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  md_busy_counter #(
    .LAT (DIV_LAT),
    .W   (8)
  ) u_md_busy (
    .clk  (clk),
    .rst  (rst),
    .load (div_issue),
    .busy (div_busy)
  );

  always_comb begin
    hz.brsrc1 = FWD_REG;
    hz.brsrc2 = FWD_REG;
    if (hz.id_is_branch && mem_q.regwrite && !mem_q.memread) begin
      if (hz.id_use_rs && (mem_q.wbadd == hz.id_rs) && (hz.id_rs != REG_ZERO))
        hz.brsrc1 = FWD_MEM;
      if (hz.id_use_rt && (mem_q.wbadd == hz.id_rt) && (hz.id_rt != REG_ZERO))
        hz.brsrc2 = FWD_MEM;
    end
  end

  assign hz.pc_en        = !stall;
  assign hz.ifid_en      = !stall;
  assign hz.idex_bubble  = stall;
  assign hz.ifid_flush   = hz.branch_taken && !stall;
  assign hz.div_busy     = div_busy;
  assign hz.stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: hand-derived expectations are queued
// with each ID instruction and compared at the following falling edge.
module tb_hazard_stall_ctrl;

  localparam int CNT_W   = 16;
  localparam int DIV_LAT = 4;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic [4:0] wbadd;
    logic       regwrite;
    logic       memread;
    logic       is_branch;
    logic       is_div;
    logic       is_mdread;
  } id_t;

  typedef struct packed {
    logic [7:0]       step;
    logic             pc_en;
    logic             bubble;
    logic             flush;
    logic [1:0]       b1;
    logic [1:0]       b2;
    logic             busy;
    logic [CNT_W-1:0] scnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.CNT_W(CNT_W)) hz();

  hazard_stall_ctrl #(
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   step   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    if (obs !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, req);
    end
  endtask

  function automatic id_t mk(input logic [4:0] rs, input logic [4:0] rt,
                             input logic urs, input logic urt, input logic [4:0] wb,
                             input logic rw, input logic mr, input logic br,
                             input logic dv, input logic md);
    id_t t;
    t.rs = rs; t.rt = rt; t.use_rs = urs; t.use_rt = urt; t.wbadd = wb;
    t.regwrite = rw; t.memread = mr; t.is_branch = br; t.is_div = dv; t.is_mdread = md;
    return t;
  endfunction

  function automatic id_t nop();                                         return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic id_t lw(input logic [4:0] d, input logic [4:0] b);  return mk(b, d, 1, 0, d, 1, 1, 0, 0, 0); endfunction
  function automatic id_t add(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
    return mk(s, t, 1, 1, d, 1, 0, 0, 0, 0);
  endfunction
  function automatic id_t beq(input logic [4:0] s, input logic [4:0] t); return mk(s, t, 1, 1, 0, 0, 0, 1, 0, 0); endfunction
  function automatic id_t div(input logic [4:0] s, input logic [4:0] t); return mk(s, t, 1, 1, 0, 0, 0, 0, 1, 0); endfunction
  function automatic id_t mflo(input logic [4:0] d);                     return mk(0, 0, 0, 0, d, 1, 0, 0, 0, 1); endfunction

  task automatic driveId(input id_t ins);
    hz.id_rs        = ins.rs;
    hz.id_rt        = ins.rt;
    hz.id_use_rs    = ins.use_rs;
    hz.id_use_rt    = ins.use_rt;
    hz.id_wbadd     = ins.wbadd;
    hz.id_regwrite  = ins.regwrite;
    hz.id_memread   = ins.memread;
    hz.id_is_branch = ins.is_branch;
    hz.id_is_div    = ins.is_div;
    hz.id_is_mdread = ins.is_mdread;
  endtask

  // Drive one cycle of ID state and queue the outputs expected for that cycle.
  task automatic applyStimulus(input id_t ins, input logic r, input logic taken,
                               input logic e_stall, input logic e_flush,
                               input logic [1:0] e_b1, input logic [1:0] e_b2,
                               input logic e_busy, input int e_scnt);
    exp_t e;
    step++;
    rst = r;
    driveId(ins);
    hz.branch_taken = taken;
    e.step   = 8'(step);
    e.pc_en  = !e_stall;
    e.bubble = e_stall;
    e.flush  = e_flush;
    e.b1     = e_b1;
    e.b2     = e_b2;
    e.busy   = e_busy;
    e.scnt   = CNT_W'(e_scnt);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checkOutput($sformatf("s%0d_pc_en",   mon_e.step), 32'(hz.pc_en),        32'(mon_e.pc_en));
      checkOutput($sformatf("s%0d_ifid_en", mon_e.step), 32'(hz.ifid_en),      32'(mon_e.pc_en));
      checkOutput($sformatf("s%0d_bubble",  mon_e.step), 32'(hz.idex_bubble),  32'(mon_e.bubble));
      checkOutput($sformatf("s%0d_flush",   mon_e.step), 32'(hz.ifid_flush),   32'(mon_e.flush));
      checkOutput($sformatf("s%0d_brsrc1",  mon_e.step), 32'(hz.brsrc1),       32'(mon_e.b1));
      checkOutput($sformatf("s%0d_brsrc2",  mon_e.step), 32'(hz.brsrc2),       32'(mon_e.b2));
      checkOutput($sformatf("s%0d_busy",    mon_e.step), 32'(hz.div_busy),     32'(mon_e.busy));
      checkOutput($sformatf("s%0d_scnt",    mon_e.step), 32'(hz.stall_cycles), 32'(mon_e.scnt));
    end
  end

  initial begin
    rst = 1'b1;
    driveId(nop());
    hz.branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    //            instr          rst taken stall flush b1     b2     busy scnt
    // reset state
    applyStimulus(nop(),         0,  0,    0,    0,    2'b00, 2'b00, 0,   0);
    // load-use, with a simultaneous taken branch that the stall must suppress
    applyStimulus(lw(8, 1),      0,  0,    0,    0,    2'b00, 2'b00, 0,   0);
    applyStimulus(add(9, 8, 1),  0,  1,    1,    0,    2'b00, 2'b00, 0,   0);
    applyStimulus(add(9, 8, 1),  0,  0,    0,    0,    2'b00, 2'b00, 0,   1);
    applyStimulus(nop(),         0,  0,    0,    0,    2'b00, 2'b00, 0,   1);
    // branch after ALU op: one stall, then forward rs from MEM and flush
    applyStimulus(add(8, 1, 2),  0,  0,    0,    0,    2'b00, 2'b00, 0,   1);
    applyStimulus(beq(8, 0),     0,  1,    1,    0,    2'b00, 2'b00, 0,   1);
    applyStimulus(beq(8, 0),     0,  1,    0,    1,    2'b01, 2'b00, 0,   2);
    applyStimulus(nop(),         0,  0,    0,    0,    2'b00, 2'b00, 0,   2);
    // branch after load: two stalls, value then comes from the register file
    applyStimulus(lw(8, 1),      0,  0,    0,    0,    2'b00, 2'b00, 0,   2);
    applyStimulus(beq(0, 8),     0,  0,    1,    0,    2'b00, 2'b00, 0,   2);
    applyStimulus(beq(0, 8),     0,  0,    1,    0,    2'b00, 2'b00, 0,   3);
    applyStimulus(beq(0, 8),     0,  0,    0,    0,    2'b00, 2'b00, 0,   4);
    applyStimulus(nop(),         0,  0,    0,    0,    2'b00, 2'b00, 0,   4);
    // writes to $0 never stall
    applyStimulus(lw(0, 1),      0,  0,    0,    0,    2'b00, 2'b00, 0,   4);
    applyStimulus(add(9, 0, 0),  0,  0,    0,    0,    2'b00, 2'b00, 0,   4);
    applyStimulus(nop(),         0,  0,    0,    0,    2'b00, 2'b00, 0,   4);
    // divide then mflo: four busy/stall cycles, mflo proceeds on the fifth
    applyStimulus(div(1, 2),     0,  0,    0,    0,    2'b00, 2'b00, 0,   4);
    applyStimulus(mflo(10),      0,  0,    1,    0,    2'b00, 2'b00, 1,   4);
    applyStimulus(mflo(10),      0,  0,    1,    0,    2'b00, 2'b00, 1,   5);
    applyStimulus(mflo(10),      0,  0,    1,    0,    2'b00, 2'b00, 1,   6);
    applyStimulus(mflo(10),      0,  0,    1,    0,    2'b00, 2'b00, 1,   7);
    applyStimulus(mflo(10),      0,  0,    0,    0,    2'b00, 2'b00, 0,   8);
    applyStimulus(nop(),         0,  0,    0,    0,    2'b00, 2'b00, 0,   8);
    // reset in the middle of a divide while a branch is taken
    applyStimulus(div(1, 2),     0,  0,    0,    0,    2'b00, 2'b00, 0,   8);
    applyStimulus(mflo(10),      0,  0,    1,    0,    2'b00, 2'b00, 1,   8);
    applyStimulus(mflo(10),      1,  1,    1,    0,    2'b00, 2'b00, 1,   9);
    applyStimulus(mflo(10),      0,  1,    0,    1,    2'b00, 2'b00, 0,   0);
    applyStimulus(nop(),         0,  0,    0,    0,    2'b00, 2'b00, 0,   0);

    for (int i = 0; i < 5 && sb.size() > 0; i++)
      @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
